sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 19; width of the SRAM byte address, equal to clog2(SRAM_SIZE).
REQ-002 SHALL have ports clk, input, 1, clock; rstn, input, 1, synchronous active-low reset.
REQ-003 SHALL have, per master port k in {0 (instruction), 1 (data)}, the following ports: mk_req in 1; mk_addr in AW; mk_w_rb in 1; mk_acc in BUS_ACC_WIDTH; mk_wdata in BUS_WIDTH; mk_rdata out BUS_WIDTH; mk_resp out 1; mk_fault out 1.
REQ-004 SHALL have the following downstream ports to the SRAM controller: s_req out 1; s_addr out AW; s_w_rb out 1; s_acc out BUS_ACC_WIDTH; s_wdata out BUS_WIDTH; s_rdata in BUS_WIDTH; s_resp in 1; s_fault in 1.

Function
REQ-005 SHALL treat mk_req as a single-cycle pulse and capture {addr, w_rb, acc, wdata} into a per-port pending slot on the same edge, setting pend_k.
REQ-006 SHALL limit each port to one outstanding request; an mk_req while pend_k or the port's transfer is in flight SHALL be dropped, with mk_fault pulsed in the same cycle (combinational).
REQ-007 SHALL implement a 3-state FSM: IDLE, ISSUE, WAIT.
REQ-008 IDLE: if any pend_k is set, select a winner, latch grant, and go to ISSUE; otherwise stay in IDLE.
REQ-009 ISSUE: drive s_req=1 for exactly one cycle with the granted slot's fields; on s_fault=1 in that cycle, pulse the granted mk_fault in the same cycle, clear its pend, and go to IDLE; otherwise go to WAIT.
REQ-010 WAIT: on s_resp=1, drive the granted mk_resp=1 and mk_rdata=s_rdata combinationally in the same cycle, clear its pend, and go to IDLE.
REQ-011 Arbitration SHALL be round-robin: when both ports are pending, grant the port not granted last; last_grant SHALL update only on an ISSUE that does not fault.
REQ-012 Minimum latency SHALL be: mk_req at cycle N, s_req at cycle N+2, mk_resp in the same cycle as s_resp.
REQ-013 Back-to-back operation: the next s_req SHALL be no earlier than 2 cycles after s_resp (IDLE, then ISSUE), which guarantees the controller busy flag has cleared.
REQ-014 s_addr, s_w_rb, s_acc and s_wdata SHALL be driven from the granted slot; they SHALL hold stable from ISSUE through WAIT and SHALL be 0 in IDLE.
REQ-015 s_resp or s_fault received outside WAIT/ISSUE respectively SHALL be ignored.
REQ-016 A new request on the non-granted port during WAIT SHALL be captured and served next.
REQ-017 mk_rdata SHALL be 0 whenever mk_resp=0.

Reset
REQ-018 On rstn=0 at a clk edge, the block SHALL: set state=IDLE; clear pend_0 and pend_1; set last_grant=1 (so m0 wins first); set s_req=0, mk_resp=0, mk_fault=0; clear all slot fields to 0.
REQ-019 A reset during WAIT SHALL abandon the transfer without any mk_resp; the controller is reset by the same rstn.
REQ-020 An mk_req in the same cycle as rstn=0 SHALL be discarded.

Structure
REQ-021 BUS_WIDTH, BUS_ACC_WIDTH, BUS_ACC_1B/2B/4B and SRAM_SIZE SHALL come from the shared bus definitions header; no local redefinition.
REQ-022 FSM state encodings SHALL be local parameters of this module.
REQ-023 The per-port pending slot (capture register, pend flag, drop-fault logic) SHALL be one sub-module, sram_arb_slot, instantiated twice.

Verification
REQ-024 Single read: m0_req, addr=0x00010, acc=4B -> s_req at N+2 with s_addr=0x00010; model resp with rdata=0xDEADBEEF -> m0_resp=1 and m0_rdata=0xDEADBEEF in the same cycle.
REQ-025 Simultaneous requests: m0_req and m1_req in the same cycle after reset -> m0 is served first, then m1; a repeat pair -> m1 first (round-robin).
REQ-026 Fault pass-through: m1 write, addr=0x00001, acc=2B -> the controller model asserts s_fault during ISSUE -> m1_fault=1 that cycle, m1_resp never asserted, FSM back in IDLE; last_grant unchanged.
REQ-027 Overrun: second m0_req while m0 is in WAIT -> m0_fault=1 in the same cycle; the original transfer completes normally with one m0_resp.
REQ-028 Reset mid-WAIT: rstn=0 for 1 cycle during WAIT -> no mk_resp, s_req=0, and the next m1 request is issued at N+2.
REQ-029 Throughput: alternating back-to-back 1B reads from both ports -> s_req gap of exactly 2 cycles after each s_resp, with no request lost.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared bus definitions and arbitration helpers for the two-master SRAM arbiter.
// Every bus width and access-size code used by the arbiter comes from here.
package sram_arbiter_pkg;

  localparam int BUS_WIDTH     = 32;
  localparam int BUS_ACC_WIDTH = 2;
  localparam int SRAM_SIZE     = 1 << 19;

  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

  typedef logic [BUS_WIDTH-1:0]     bus_data_t;
  typedef logic [BUS_ACC_WIDTH-1:0] bus_acc_t;

  // Round-robin pick: on contention the port not granted last wins,
  // otherwise whichever single port is pending.
  function automatic logic pick_winner(input logic pend0,
                                       input logic pend1,
                                       input logic last_grant);
    if (pend0 && pend1) begin
      return ~last_grant;
    end
    return pend1;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// One SRAM bus link; used for both master ports and the controller side.
// Handshake: req is a one-cycle pulse carrying addr/w_rb/acc/wdata; the
// target answers later with a one-cycle resp (rdata valid only with resp)
// or a one-cycle fault; at most one request is outstanding per link.
interface sram_arbiter_if #(
  parameter int AW = $clog2(sram_arbiter_pkg::SRAM_SIZE)
);
  import sram_arbiter_pkg::*;

  logic      req;
  logic [AW-1:0] addr;
  logic      w_rb;
  bus_acc_t  acc;
  bus_data_t wdata;
  bus_data_t rdata;
  logic      resp;
  logic      fault;

  modport master (
    output req,
    output addr,
    output w_rb,
    output acc,
    output wdata,
    input  rdata,
    input  resp,
    input  fault
  );

  modport slave (
    input  req,
    input  addr,
    input  w_rb,
    input  acc,
    input  wdata,
    output rdata,
    output resp,
    output fault
  );

endinterface

// File: rtl/sram_arb_slot.sv
// Per-master pending slot: captures a request pulse, holds it until the arbiter
// clears it, and flags any request that arrives while one is already held.
module sram_arb_slot
  import sram_arbiter_pkg::*;
#(
  parameter int AW = $clog2(SRAM_SIZE)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_w_rb,
  input  bus_acc_t      i_acc,
  input  bus_data_t     i_wdata,
  input  logic          i_clr,
  output logic          o_pend,
  output logic [AW-1:0] o_addr,
  output logic          o_w_rb,
  output bus_acc_t      o_acc,
  output bus_data_t     o_wdata,
  output logic          o_drop_fault
);

  logic          r_pend;
  logic [AW-1:0] r_addr;
  logic          r_w_rb;
  bus_acc_t      r_acc;
  bus_data_t     r_wdata;
  logic          w_accept;

  // pend stays set through issue and wait, so it alone marks the port busy.
  assign w_accept = i_req && !r_pend;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pend  <= 1'b0;
      r_addr  <= '0;
      r_w_rb  <= 1'b0;
      r_acc   <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_pend  <= 1'b1;
      r_addr  <= i_addr;
      r_w_rb  <= i_w_rb;
      r_acc   <= i_acc;
      r_wdata <= i_wdata;
    end else if (i_clr) begin
      r_pend  <= 1'b0;
    end
  end

  assign o_pend       = r_pend;
  assign o_addr       = r_addr;
  assign o_w_rb       = r_w_rb;
  assign o_acc        = r_acc;
  assign o_wdata      = r_wdata;
  assign o_drop_fault = rstn && i_req && r_pend;

endmodule

// File: rtl/sram_arbiter.sv
// Two-master (instruction m0, data m1) round-robin arbiter in front of a
// single-outstanding SRAM controller; IDLE -> ISSUE -> WAIT per transfer.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int AW = $clog2(SRAM_SIZE)
) (
  input  logic                clk,
  input  logic                rstn,
  sram_arbiter_if.slave       m0,
  sram_arbiter_if.slave       m1,
  sram_arbiter_if.master      s,
  output logic [1:0]          o_dbg_state,
  output logic                o_dbg_last_grant
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_grant;
  logic   w_grant_nxt;
  logic   r_last_grant;
  logic   w_last_grant_nxt;

  logic          w_pend0;
  logic          w_pend1;
  logic [AW-1:0] w_addr0;
  logic [AW-1:0] w_addr1;
  logic          w_w_rb0;
  logic          w_w_rb1;
  bus_acc_t      w_acc0;
  bus_acc_t      w_acc1;
  bus_data_t     w_wdata0;
  bus_data_t     w_wdata1;
  logic          w_drop0;
  logic          w_drop1;

  logic [1:0]    w_clr;
  logic [1:0]    w_resp;
  logic [1:0]    w_issue_fault;
  logic          w_s_req;
  logic          w_busy;

  sram_arb_slot #(.AW(AW)) u_slot0 (
    .clk          (clk),
    .rstn         (rstn),
    .i_req        (m0.req),
    .i_addr       (m0.addr),
    .i_w_rb       (m0.w_rb),
    .i_acc        (m0.acc),
    .i_wdata      (m0.wdata),
    .i_clr        (w_clr[0]),
    .o_pend       (w_pend0),
    .o_addr       (w_addr0),
    .o_w_rb       (w_w_rb0),
    .o_acc        (w_acc0),
    .o_wdata      (w_wdata0),
    .o_drop_fault (w_drop0)
  );

  sram_arb_slot #(.AW(AW)) u_slot1 (
    .clk          (clk),
    .rstn         (rstn),
    .i_req        (m1.req),
    .i_addr       (m1.addr),
    .i_w_rb       (m1.w_rb),
    .i_acc        (m1.acc),
    .i_wdata      (m1.wdata),
    .i_clr        (w_clr[1]),
    .o_pend       (w_pend1),
    .o_addr       (w_addr1),
    .o_w_rb       (w_w_rb1),
    .o_acc        (w_acc1),
    .o_wdata      (w_wdata1),
    .o_drop_fault (w_drop1)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_clr            = 2'b00;
    w_resp           = 2'b00;
    w_issue_fault    = 2'b00;
    w_s_req          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pend0 || w_pend1) begin
          w_grant_nxt = pick_winner(w_pend0, w_pend1, r_last_grant);
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_s_req = 1'b1;
        // A faulted issue does not count as a turn for round-robin.
        if (s.fault) begin
          w_issue_fault[r_grant] = 1'b1;
          w_clr[r_grant]         = 1'b1;
          w_state_nxt            = ST_IDLE;
        end else begin
          w_last_grant_nxt = r_grant;
          w_state_nxt      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (s.resp) begin
          w_resp[r_grant] = 1'b1;
          w_clr[r_grant]  = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Downstream fields follow the granted slot while a transfer is live.
  assign w_busy  = (r_state != ST_IDLE);
  assign s.req   = w_s_req;
  assign s.addr  = w_busy ? (r_grant ? w_addr1  : w_addr0)  : '0;
  assign s.w_rb  = w_busy ? (r_grant ? w_w_rb1  : w_w_rb0)  : 1'b0;
  assign s.acc   = w_busy ? (r_grant ? w_acc1   : w_acc0)   : '0;
  assign s.wdata = w_busy ? (r_grant ? w_wdata1 : w_wdata0) : '0;

  // Completion pulses are suppressed while reset is held so an abandoned
  // transfer never reports back.
  assign m0.resp  = rstn && w_resp[0];
  assign m1.resp  = rstn && w_resp[1];
  assign m0.rdata = m0.resp ? s.rdata : '0;
  assign m1.rdata = m1.resp ? s.rdata : '0;
  assign m0.fault = w_drop0 || (rstn && w_issue_fault[0]);
  assign m1.fault = w_drop1 || (rstn && w_issue_fault[1]);

  assign o_dbg_state      = r_state;
  assign o_dbg_last_grant = r_last_grant;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: drives both masters, models the SRAM
// controller, and checks every issue/response against an expected queue.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int AW = $clog2(SRAM_SIZE);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  // Queue entry: {port, w_rb, acc, addr, wdata, rdata}
  localparam int EW = 1 + 1 + BUS_ACC_WIDTH + AW + BUS_WIDTH + BUS_WIDTH;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] dbg_state;
  logic       dbg_last_grant;
  int         errors = 0;
  int         checks = 0;
  logic [EW-1:0] exp_q[$];

  sram_arbiter_if #(.AW(AW)) m0_if ();
  sram_arbiter_if #(.AW(AW)) m1_if ();
  sram_arbiter_if #(.AW(AW)) s_if ();

  always #5 clk = ~clk;

  sram_arbiter #(.AW(AW)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .m0               (m0_if),
    .m1               (m1_if),
    .s                (s_if),
    .o_dbg_state      (dbg_state),
    .o_dbg_last_grant (dbg_last_grant)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Controller memory model.
  function automatic logic [BUS_WIDTH-1:0] mem_data(input logic [AW-1:0] a);
    if (a == AW'(32'h10)) return 32'hDEAD_BEEF;
    return {a[12:0], a} ^ 32'h3C5A_9600;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    m0_if.req   = 1'b0;
    m1_if.req   = 1'b0;
    s_if.resp   = 1'b0;
    s_if.fault  = 1'b0;
    s_if.rdata  = $urandom();
  endtask

  task automatic send(input bit port, input logic [AW-1:0] a, input logic w_rb,
                      input logic [BUS_ACC_WIDTH-1:0] acc, input logic [BUS_WIDTH-1:0] wd,
                      input bit expect_served);
    if (port) begin
      m1_if.req = 1'b1; m1_if.addr = a; m1_if.w_rb = w_rb; m1_if.acc = acc; m1_if.wdata = wd;
    end else begin
      m0_if.req = 1'b1; m0_if.addr = a; m0_if.w_rb = w_rb; m0_if.acc = acc; m0_if.wdata = wd;
    end
    if (expect_served) exp_q.push_back({port, w_rb, acc, a, wd, mem_data(a)});
  endtask

  // Waits for the next s_req, checks it against the queue head, then plays the
  // controller: fault in ISSUE, or resp after wait_cycles idle WAIT cycles.
  // inj=1: overrun on the granted port in the first WAIT cycle.
  // inj=2: new request on the other port in the first WAIT cycle.
  task automatic serve(input int wait_cycles, input bit do_fault, input int inj, output int lat);
    logic [EW-1:0] e;
    bit ep;
    logic ew;
    logic [BUS_ACC_WIDTH-1:0] eacc;
    logic [AW-1:0] ea;
    logic [BUS_WIDTH-1:0] ewd;
    logic [BUS_WIDTH-1:0] ed;
    logic [AW-1:0] held;
    lat = 0;
    do begin
      next_cycle(); #1; lat++;
    end while (!s_if.req && lat < 12);
    chk("sreq_seen", s_if.req, 1);
    if (!s_if.req) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      return;
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    {ep, ew, eacc, ea, ewd, ed} = e;
    chk("issue_state", dbg_state, S_ISSUE);
    chk("issue_addr", s_if.addr, ea);
    chk("issue_w_rb", s_if.w_rb, ew);
    chk("issue_acc", s_if.acc, eacc);
    chk("issue_wdata", s_if.wdata, ewd);
    held = s_if.addr;
    if (do_fault) begin
      s_if.fault = 1'b1; #1;
      chk("fault_port", ep ? m1_if.fault : m0_if.fault, 1);
      chk("fault_other", ep ? m0_if.fault : m1_if.fault, 0);
      chk("fault_noresp", m0_if.resp | m1_if.resp, 0);
      next_cycle(); #1;
      chk("fault_idle", dbg_state, S_IDLE);
      chk("fault_idle_addr", s_if.addr, 0);
      chk("fault_noreq", s_if.req, 0);
      return;
    end
    for (int i = 0; i <= wait_cycles; i++) begin
      next_cycle();
      if (i == 0 && inj == 1) send(ep, ea ^ AW'(1), 1'b0, BUS_ACC_4B, '0, 0);
      if (i == 0 && inj == 2) send(!ep, ea ^ AW'(32'h100), 1'b0, BUS_ACC_1B, '0, 1);
      if (i == wait_cycles) begin
        s_if.resp  = 1'b1;
        s_if.rdata = mem_data(s_if.addr);
      end
      #1;
      chk("wait_state", dbg_state, S_WAIT);
      chk("wait_addr_hold", s_if.addr, held);
      chk("wait_noreq", s_if.req, 0);
      if (i == 0 && inj == 1) chk("overrun_fault", ep ? m1_if.fault : m0_if.fault, 1);
      if (i == 0 && inj == 2) chk("capture_nofault", ep ? m0_if.fault : m1_if.fault, 0);
      if (i < wait_cycles) begin
        chk("wait_noresp", m0_if.resp | m1_if.resp, 0);
        chk("wait_rdata_zero", {m0_if.rdata, m1_if.rdata}, 0);
      end
    end
    chk("resp_port", ep ? m1_if.resp : m0_if.resp, 1);
    chk("resp_other", ep ? m0_if.resp : m1_if.resp, 0);
    chk("resp_data", ep ? m1_if.rdata : m0_if.rdata, ed);
    chk("rdata_other_zero", ep ? m0_if.rdata : m1_if.rdata, 0);
  endtask

  initial begin
    int lat;
    m0_if.req = 1'b0; m0_if.addr = '0; m0_if.w_rb = 1'b0; m0_if.acc = '0; m0_if.wdata = '0;
    m1_if.req = 1'b0; m1_if.addr = '0; m1_if.w_rb = 1'b0; m1_if.acc = '0; m1_if.wdata = '0;
    s_if.rdata = '0; s_if.resp = 1'b0; s_if.fault = 1'b0;

    // Reset, with a request pulse in the last reset cycle that must vanish.
    rstn = 1'b0;
    repeat (2) next_cycle();
    next_cycle();
    send(0, AW'(32'h77), 1'b0, BUS_ACC_4B, '0, 0);
    #1;
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_last_grant", dbg_last_grant, 1);
    chk("rst_sreq", s_if.req, 0);
    chk("rst_saddr", s_if.addr, 0);
    chk("rst_fault", m0_if.fault | m1_if.fault, 0);
    chk("rst_resp", m0_if.resp | m1_if.resp, 0);
    next_cycle();
    rstn = 1'b1;
    repeat (4) begin
      next_cycle(); #1;
      chk("rst_req_discarded", s_if.req, 0);
    end

    // Simultaneous pair after reset: m0 first, then m1.
    next_cycle();
    send(0, AW'(32'h100), 1'b0, BUS_ACC_4B, '0, 1);
    send(1, AW'(32'h204), 1'b0, BUS_ACC_2B, '0, 1);
    serve(1, 0, 0, lat); chk("pair1_lat_m0", lat, 2);
    serve(0, 0, 0, lat); chk("pair1_lat_m1", lat, 2);

    // Single read at 0x10 returning DEADBEEF; leaves last_grant = m0.
    next_cycle();
    send(0, AW'(32'h10), 1'b0, BUS_ACC_4B, '0, 1);
    serve(2, 0, 0, lat); chk("single_lat", lat, 2);

    // Repeat pair: m1 now wins first.
    next_cycle();
    send(1, AW'(32'h308), 1'b1, BUS_ACC_4B, 32'hCAFE_F00D, 1);
    send(0, AW'(32'h30C), 1'b0, BUS_ACC_1B, '0, 1);
    serve(0, 0, 0, lat); chk("pair2_lat_m1", lat, 2);
    serve(1, 0, 0, lat); chk("pair2_lat_m0", lat, 2);
    chk("pair2_last_grant", dbg_last_grant, 0);

    // Controller fault on an m1 2B write; last_grant stays at m0.
    next_cycle();
    send(1, AW'(32'h1), 1'b1, BUS_ACC_2B, 32'hA5A5_5A5A, 1);
    serve(0, 1, 0, lat); chk("fault_lat", lat, 2);
    chk("fault_last_grant", dbg_last_grant, 0);
    repeat (3) begin
      next_cycle(); #1;
      chk("fault_no_late_resp", m1_if.resp, 0);
      chk("fault_stays_idle", dbg_state, S_IDLE);
    end

    // Overrun on m0 during WAIT: dropped with fault, original completes once.
    next_cycle();
    send(0, AW'(32'h20), 1'b0, BUS_ACC_4B, '0, 1);
    serve(2, 0, 1, lat); chk("overrun_lat", lat, 2);
    repeat (4) begin
      next_cycle(); #1;
      chk("overrun_no_reissue", s_if.req, 0);
    end

    // m1 request arriving while m0 waits is captured and served next.
    next_cycle();
    send(0, AW'(32'h30), 1'b0, BUS_ACC_4B, '0, 1);
    serve(1, 0, 2, lat); chk("capture_lat_m0", lat, 2);
    serve(0, 0, 0, lat); chk("capture_lat_m1", lat, 2);

    // Reset while m0 waits: transfer abandoned, stale resp/fault ignored.
    next_cycle();
    send(0, AW'(32'h200), 1'b0, BUS_ACC_4B, '0, 0);
    repeat (2) next_cycle();
    #1;
    chk("rstw_issue", s_if.req, 1);
    next_cycle(); #1;
    chk("rstw_wait", dbg_state, S_WAIT);
    next_cycle();
    rstn = 1'b0;
    #1;
    chk("rstw_noresp", m0_if.resp | m1_if.resp, 0);
    chk("rstw_sreq", s_if.req, 0);
    next_cycle();
    rstn = 1'b1;
    s_if.resp  = 1'b1;
    s_if.fault = 1'b1;
    #1;
    chk("rstw_idle", dbg_state, S_IDLE);
    chk("rstw_last_grant", dbg_last_grant, 1);
    chk("rstw_stale_resp", m0_if.resp | m1_if.resp, 0);
    chk("rstw_stale_fault", m0_if.fault | m1_if.fault, 0);
    chk("rstw_saddr_zero", s_if.addr, 0);
    next_cycle();
    send(1, AW'(32'h300), 1'b1, BUS_ACC_4B, 32'h1234_5678, 1);
    serve(1, 0, 0, lat); chk("rstw_next_lat", lat, 2);

    // Alternating back-to-back 1B reads; each served port re-requests in IDLE.
    next_cycle();
    send(0, AW'(32'h400), 1'b0, BUS_ACC_1B, '0, 1);
    send(1, AW'(32'h500), 1'b0, BUS_ACC_1B, '0, 1);
    serve(0, 0, 0, lat); chk("tp_first_lat", lat, 2);
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      send(k[0], AW'(32'h600 + k * 8 + $urandom_range(0, 3)), 1'b0, BUS_ACC_1B, '0, 1);
      serve(0, 0, 0, lat); chk("tp_gap", lat, 1);
    end
    serve(0, 0, 0, lat); chk("tp_last_lat", lat, 2);
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
